// File: rtl/parking_sensor_fsm_if.sv
// Sensor/pulse bundle between the raw beam sensors, the parking-sensor front end
// and the downstream occupancy counter.
interface parking_sensor_fsm_if;
  logic sw1;
  logic sw2;
  logic enter;
  logic exit;
  logic seq_err;
  logic busy;

  modport master (
    output sw1, sw2,
    input  enter, exit, seq_err, busy
  );

  modport slave (
    input  sw1, sw2,
    output enter, exit, seq_err, busy
  );
endinterface

// File: rtl/parking_sensor_fsm.sv
// Parking-lot entry front end: synchronises and debounces beams A/B and decodes
// the occlusion sequence into one-cycle enter / exit / seq_err pulses.
module parking_sensor_fsm #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int DB_W        = 8
) (
  input  logic                 clk,
  input  logic                 async_reset,
  parking_sensor_fsm_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, ERR} state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) rst_pipe <= '0;
    else              rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Index 1 = beam A (outer, sw1), index 0 = beam B (inner, sw2).
  logic [1:0] raw;
  logic [1:0] ab;

  assign raw = {bus.sw1, bus.sw2};

  for (genvar i = 0; i < 2; i++) begin : g_sensor
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   filt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: non-blocking assignments let every flop sample the pre-edge value,
    // so the shift register really has SYNC_STAGES stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        db_cnt <= '0;
        filt_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
        if (synced == filt_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          filt_q <= synced;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    assign ab[i] = filt_q;
  end

  // Sensor pattern each legal state is waiting in.
  function automatic logic [1:0] ab_of(state_t s);
    case (s)
      E1, X3:  ab_of = 2'b10;
      E2, X2:  ab_of = 2'b11;
      E3, X1:  ab_of = 2'b01;
      default: ab_of = 2'b00;
    endcase
  endfunction

  state_t state;
  logic   enter_q, exit_q, seq_err_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      enter_q   <= 1'b0;
      exit_q    <= 1'b0;
      seq_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      enter_q   <= 1'b0;
      exit_q    <= 1'b0;
      seq_err_q <= 1'b0;
      if (state == ERR) begin
        if (ab == 2'b00) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      end else if (ab == ~ab_of(state)) begin
        state     <= ERR;
        busy_q    <= 1'b1;
        seq_err_q <= 1'b1;
      end else if (ab != ab_of(state)) begin
        // Exactly one beam changed; branches returning to IDLE clear busy.
        busy_q <= 1'b1;
        unique case (state)
          IDLE: state <= ab[1] ? E1 : X1;
          E1: begin
            if (ab[0]) state <= E2;
            else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          E2: state <= ab[1] ? E1 : E3;
          E3: begin
            if (ab[1]) state <= E2;
            else begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              enter_q <= 1'b1;
            end
          end
          X1: begin
            if (ab[1]) state <= X2;
            else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          X2: state <= ab[1] ? X3 : X1;
          X3: begin
            if (ab[0]) state <= X2;
            else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              exit_q <= 1'b1;
            end
          end
          default: state <= ERR;
        endcase
      end
    end
  end

  assign bus.enter   = enter_q;
  assign bus.exit    = exit_q;
  assign bus.seq_err = seq_err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// Directed bench for parking_sensor_fsm: pulses are predicted into a scoreboard
// with their arrival cycle and matched by a monitor as the DUT emits them.
module tb_parking_sensor_fsm;

  typedef enum logic [1:0] {K_ENTER, K_EXIT, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    int unsigned cyc;
  } exp_t;

  localparam int LAT  = 7;
  localparam int HOLD = 50;

  logic        clk = 1'b0;
  logic        async_reset;
  int unsigned cyc = 0;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_pulse = 1'b0;

  parking_sensor_fsm_if bus ();

  parking_sensor_fsm #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4),
    .DB_W       (8)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every emitted pulse must match the oldest prediction, on time.
  always @(negedge clk) begin
    logic  any;
    kind_t k;
    exp_t  e;
    any = bus.enter | bus.exit | bus.seq_err;
    if (any === 1'b1) begin
      k = bus.enter ? K_ENTER : (bus.exit ? K_EXIT : K_ERR);
      check("pulse_onehot", 32'($countones({bus.enter, bus.exit, bus.seq_err})), 32'd1);
      check("pulse_back_to_back", 32'(prev_pulse), 32'd0);
      check("pulse_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_kind", 32'(k), 32'(e.kind));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
    prev_pulse = (any === 1'b1);
  end

  task automatic step(input string tag, input logic a, input logic b,
                      input logic exp_busy, input bit push, input kind_t k);
    @(negedge clk);
    bus.sw1 = a;
    bus.sw2 = b;
    if (push) sb.push_back('{k, cyc + LAT});
    repeat (HOLD) @(negedge clk);
    check(tag, 32'(bus.busy), 32'(exp_busy));
  endtask

  task automatic entry(input string tag);
    step({tag, "_busy10"}, 1'b1, 1'b0, 1'b1, 1'b0, K_ENTER);
    step({tag, "_busy11"}, 1'b1, 1'b1, 1'b1, 1'b0, K_ENTER);
    step({tag, "_busy01"}, 1'b0, 1'b1, 1'b1, 1'b0, K_ENTER);
    step({tag, "_busy00"}, 1'b0, 1'b0, 1'b0, 1'b1, K_ENTER);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_a(input int width, output logic busy_seen);
    busy_seen = 1'b0;
    @(negedge clk);
    bus.sw1 = 1'b1;
    repeat (width) begin
      @(negedge clk);
      busy_seen |= bus.busy;
    end
    bus.sw1 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      busy_seen |= bus.busy;
    end
  endtask

  initial begin
    logic seen;
    async_reset = 1'b0;
    bus.sw1     = 1'b0;
    bus.sw2     = 1'b0;
    #1;
    check("rst_enter",   32'(bus.enter),   32'd0);
    check("rst_exit",    32'(bus.exit),    32'd0);
    check("rst_seq_err", 32'(bus.seq_err), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    repeat (3) @(negedge clk);
    async_reset = 1'b1;
    repeat (10) @(negedge clk);

    // Single entry, then a single exit.
    entry("entry");
    step("exit_busy01", 1'b0, 1'b1, 1'b1, 1'b0, K_EXIT);
    step("exit_busy11", 1'b1, 1'b1, 1'b1, 1'b0, K_EXIT);
    step("exit_busy10", 1'b1, 1'b0, 1'b1, 1'b0, K_EXIT);
    step("exit_busy00", 1'b0, 1'b0, 1'b0, 1'b1, K_EXIT);
    check("exit_drained", 32'(sb.size()), 32'd0);

    // Eleven back-to-back entries.
    for (int i = 0; i < 11; i++) entry($sformatf("burst%0d", i));

    // Car backs out of the entry lane: no pulse.
    step("back_busy10", 1'b1, 1'b0, 1'b1, 1'b0, K_ENTER);
    step("back_busy11", 1'b1, 1'b1, 1'b1, 1'b0, K_ENTER);
    step("back_busy10b", 1'b1, 1'b0, 1'b1, 1'b0, K_ENTER);
    step("back_busy00", 1'b0, 1'b0, 1'b0, 1'b0, K_ENTER);

    // Glitches on A: 3 clocks rejected, 4 clocks reaches E1 and returns.
    pulse_a(3, seen);
    check("glitch3_busy_seen", 32'(seen), 32'd0);
    pulse_a(4, seen);
    check("glitch4_busy_seen", 32'(seen), 32'd1);
    check("glitch4_busy_end", 32'(bus.busy), 32'd0);

    // Both beams together: seq_err, ERR holds until 00, then a clean entry.
    step("illegal_busy11", 1'b1, 1'b1, 1'b1, 1'b1, K_ERR);
    step("illegal_busy10", 1'b1, 1'b0, 1'b1, 1'b0, K_ERR);
    step("illegal_busy00", 1'b0, 1'b0, 1'b0, 1'b0, K_ERR);
    entry("post_err");

    // Reset while in E2 discards the partial entry.
    step("rst_mid_busy10", 1'b1, 1'b0, 1'b1, 1'b0, K_ENTER);
    step("rst_mid_busy11", 1'b1, 1'b1, 1'b1, 1'b0, K_ENTER);
    @(negedge clk);
    #2;
    async_reset = 1'b0;
    #1;
    check("midrst_enter",   32'(bus.enter),   32'd0);
    check("midrst_exit",    32'(bus.exit),    32'd0);
    check("midrst_seq_err", 32'(bus.seq_err), 32'd0);
    check("midrst_busy",    32'(bus.busy),    32'd0);
    bus.sw1 = 1'b0;
    bus.sw2 = 1'b0;
    repeat (5) @(negedge clk);
    async_reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    entry("post_rst");

    repeat (20) @(negedge clk);
    check("final_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
